// File: rtl/ibr128_pkg.sv
// Shared constants, FSM state type and padding helper for the IBR128 block packer.
// Padding style depends on IBR128_PKCS7_PAD_EN: PKCS#7 when defined, zero fill otherwise.
package ibr128_pkg;

   localparam int unsigned BLK_W         = 128;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned WORDS_PER_BLK = 4;
   localparam int unsigned BLK_BYTES     = BLK_W / 8;
   localparam int unsigned BYTES_W       = 5;

   typedef enum logic [1:0] {
      StFill,
      StStall,
      StPadBlk
   } state_e;

   // Keeps the first nbytes bytes (stream order, MSB first) and fills the rest.
   // nbytes == 0 yields a block made entirely of fill bytes.
   function automatic logic [BLK_W-1:0] pad_fill(input logic [BLK_W-1:0]   blk,
                                                 input logic [BYTES_W-1:0] nbytes);
      logic [BLK_W-1:0] res;
      logic [7:0]       pad_byte;
`ifdef IBR128_PKCS7_PAD_EN
      pad_byte = 8'(BLK_BYTES) - {3'b000, nbytes};
`else
      pad_byte = 8'h00;
`endif
      res = blk;
      for (int i = 0; i < int'(BLK_BYTES); i++) begin
         if (i >= int'(nbytes)) begin
            res[BLK_W-1-8*i -: 8] = pad_byte;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ibr128_pad_fill.sv
// Combinational padding of a partially filled block; fill style set by IBR128_PKCS7_PAD_EN.
module ibr128_pad_fill
   import ibr128_pkg::*;
(
   input  logic [BLK_W-1:0]   blk_i,
   input  logic [BYTES_W-1:0] nbytes_i,
   output logic [BLK_W-1:0]   padded_o
);

   always_comb begin
      padded_o = pad_fill(blk_i, nbytes_i);
   end

endmodule

// File: rtl/ibr128_block_packer.sv
// Packs a 32-bit word stream into 128-bit blocks with a double-buffered output stage.
// IBR128_PKCS7_PAD_EN selects PKCS#7 padding and the trailing full pad block.
module ibr128_block_packer #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned BLK_W  = 128,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Enable,
   input  logic [WORD_W-1:0] InData,
   input  logic              InValid,
   input  logic              InLast,
   input  logic [1:0]        InLastBytes,
   output logic              InReady,
   output logic [BLK_W-1:0]  BlkData,
   output logic [4:0]        BlkBytes,
   output logic              BlkLast,
   output logic              BlkValid,
   input  logic              BlkReady,
   output logic [CNT_W-1:0]  BlkCount
);

   import ibr128_pkg::*;

   localparam int unsigned IDX_W = $clog2(WORDS_PER_BLK);

`ifdef IBR128_PKCS7_PAD_EN
   localparam logic [BLK_W-1:0] PadBlock = {(BLK_W/8){8'h10}};
`endif

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BLK_W-1:0]   asm_q, asm_d;
   logic [BYTES_W-1:0] pend_bytes_q, pend_bytes_d;
   logic               pend_last_q, pend_last_d;
   logic               pad_pend_q, pad_pend_d;
   logic               rdy_q, rdy_d;
   logic [BLK_W-1:0]   out_data_q, out_data_d;
   logic [BYTES_W-1:0] out_bytes_q, out_bytes_d;
   logic               out_last_q, out_last_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               accept, drain, out_free, cplt, pad_need, cplt_last;
   logic [2:0]         last_bytes;
   logic [BYTES_W-1:0] cplt_bytes;
   logic [BLK_W-1:0]   asm_wr, padded;

   assign accept   = InValid & InReady;
   assign drain    = out_valid_q & BlkReady;
   assign out_free = ~out_valid_q | BlkReady;

   always_comb begin
      asm_wr = asm_q;
      for (int w = 0; w < int'(WORDS_PER_BLK); w++) begin
         if (int'(idx_q) == w) begin
            asm_wr[BLK_W-1-WORD_W*w -: WORD_W] = InData;
         end
      end
   end

   // A last word carries 1..4 bytes; the encoding 0 means a full word.
   assign last_bytes = (InLastBytes == 2'd0) ? 3'd4 : {1'b0, InLastBytes};
   assign cplt       = accept & (InLast | (&idx_q));
   assign cplt_bytes = InLast ? ({1'b0, idx_q, 2'b00} + {2'b00, last_bytes}) : 5'd16;

`ifdef IBR128_PKCS7_PAD_EN
   // An exactly-full final block still needs a whole pad block after it.
   assign pad_need = InLast & (cplt_bytes == 5'd16);
`else
   assign pad_need = 1'b0;
`endif
   assign cplt_last = InLast & ~pad_need;

   ibr128_pad_fill u_pad_fill (
      .blk_i    (asm_wr),
      .nbytes_i (cplt_bytes),
      .padded_o (padded)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      asm_d        = asm_q;
      pend_bytes_d = pend_bytes_q;
      pend_last_d  = pend_last_q;
      pad_pend_d   = pad_pend_q;
      out_data_d   = out_data_q;
      out_bytes_d  = out_bytes_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q & ~drain;
      cnt_d        = drain ? cnt_q + 1'b1 : cnt_q;

      unique case (state_q)
         StFill: begin
            if (accept) begin
               if (cplt) begin
                  idx_d = '0;
                  if (out_free) begin
                     out_data_d  = padded;
                     out_bytes_d = cplt_bytes;
                     out_last_d  = cplt_last;
                     out_valid_d = 1'b1;
                     state_d     = pad_need ? StPadBlk : StFill;
                  end else begin
                     // Park the finished block in ASM until OUT frees up.
                     asm_d        = padded;
                     pend_bytes_d = cplt_bytes;
                     pend_last_d  = cplt_last;
                     pad_pend_d   = pad_need;
                     state_d      = StStall;
                  end
               end else begin
                  asm_d = asm_wr;
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StStall: begin
            if (out_free) begin
               out_data_d  = asm_q;
               out_bytes_d = pend_bytes_q;
               out_last_d  = pend_last_q;
               out_valid_d = 1'b1;
               state_d     = pad_pend_q ? StPadBlk : StFill;
            end
         end
         StPadBlk: begin
`ifdef IBR128_PKCS7_PAD_EN
            if (out_free) begin
               out_data_d  = PadBlock;
               out_bytes_d = '0;
               out_last_d  = 1'b1;
               out_valid_d = 1'b1;
               state_d     = StFill;
            end
`else
            state_d = StFill;
`endif
         end
         default: state_d = StFill;
      endcase

      rdy_d = (state_d == StFill);
   end

   always_ff @(posedge Clk) begin
      if (Rst || !Enable) begin
         state_q      <= StFill;
         idx_q        <= '0;
         asm_q        <= '0;
         pend_bytes_q <= '0;
         pend_last_q  <= 1'b0;
         pad_pend_q   <= 1'b0;
         rdy_q        <= 1'b0;
         out_data_q   <= '0;
         out_bytes_q  <= '0;
         out_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         if (Rst) begin
            cnt_q <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         pend_bytes_q <= pend_bytes_d;
         pend_last_q  <= pend_last_d;
         pad_pend_q   <= pad_pend_d;
         rdy_q        <= rdy_d;
         out_data_q   <= out_data_d;
         out_bytes_q  <= out_bytes_d;
         out_last_q   <= out_last_d;
         out_valid_q  <= out_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign InReady  = rdy_q & Enable;
   assign BlkData  = out_data_q;
   assign BlkBytes = out_bytes_q;
   assign BlkLast  = out_last_q;
   assign BlkValid = out_valid_q;
   assign BlkCount = cnt_q;

endmodule

// File: tb/tb_ibr128_block_packer.sv
// Bench for ibr128_block_packer: byte-queue scoreboard plus directed literal checks.
// Expectations follow IBR128_PKCS7_PAD_EN the same way the design does.
module tb_ibr128_block_packer;

   logic         Clk = 1'b0;
   logic         Rst, Enable, InValid, InLast, InReady, BlkLast, BlkValid, BlkReady;
   logic [31:0]  InData;
   logic [1:0]   InLastBytes;
   logic [127:0] BlkData;
   logic [4:0]   BlkBytes;
   logic [15:0]  BlkCount;

   always #5 Clk = ~Clk;

   ibr128_block_packer #(
      .WORD_W (32),
      .BLK_W  (128),
      .CNT_W  (16)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Enable      (Enable),
      .InData      (InData),
      .InValid     (InValid),
      .InLast      (InLast),
      .InLastBytes (InLastBytes),
      .InReady     (InReady),
      .BlkData     (BlkData),
      .BlkBytes    (BlkBytes),
      .BlkLast     (BlkLast),
      .BlkValid    (BlkValid),
      .BlkReady    (BlkReady),
      .BlkCount    (BlkCount)
   );

   typedef struct packed {
      logic [127:0] data;
      logic [4:0]   nbytes;
      logic         last;
   } blk_t;

   blk_t        sb[$];
   logic [7:0]  pend[$];
   logic [15:0] cnt_m;
   bit          mon_en;
   int          tests, fails;
   bit          hold_v;
   blk_t        hold_b, mon_b;
   logic [31:0] mon_w;
   int          mon_nv;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Turn the pending message bytes into the block(s) the packer must emit.
   task automatic close_block(input logic last);
      blk_t       b;
      int         n;
      logic [7:0] pv;
      n = pend.size();
`ifdef IBR128_PKCS7_PAD_EN
      pv = 8'(16 - n);
`else
      pv = 8'h00;
`endif
      b.data = '0;
      for (int i = 0; i < 16; i++) begin
         b.data = {b.data[119:0], (i < n) ? pend[i] : pv};
      end
      b.nbytes = 5'(n);
      b.last   = last;
`ifdef IBR128_PKCS7_PAD_EN
      if (last && n == 16) begin
         b.last = 1'b0;
         sb.push_back(b);
         b.data   = {16{8'h10}};
         b.nbytes = 5'd0;
         b.last   = 1'b1;
      end
`endif
      sb.push_back(b);
      pend.delete();
   endtask

   // Sampled mid-cycle: the values seen here are those the next rising edge acts on.
   always @(negedge Clk) begin
      if (mon_en) begin
         check("blk_count", BlkCount, cnt_m);
         if (hold_v && BlkValid) begin
            check("hold_data", BlkData, hold_b.data);
            check("hold_meta", {BlkBytes, BlkLast}, {hold_b.nbytes, hold_b.last});
         end
         hold_v = 1'b0;
         if (Rst || !Enable) begin
            sb.delete();
            pend.delete();
            if (Rst) cnt_m = '0;
         end else begin
            if (BlkValid && BlkReady) begin
               if (sb.size() == 0) begin
                  check("unexpected_blk", BlkValid, 1'b0);
               end else begin
                  mon_b = sb.pop_front();
                  check("blk_data", BlkData, mon_b.data);
                  check("blk_bytes", BlkBytes, mon_b.nbytes);
                  check("blk_last", BlkLast, mon_b.last);
               end
               cnt_m = cnt_m + 16'd1;
            end
            if (BlkValid && !BlkReady) begin
               hold_v = 1'b1;
               hold_b = {BlkData, BlkBytes, BlkLast};
            end
            if (InValid && InReady) begin
               mon_nv = (!InLast || InLastBytes == 2'd0) ? 4 : int'(InLastBytes);
               mon_w  = InData;
               for (int k = 0; k < mon_nv; k++) begin
                  pend.push_back(mon_w[31:24]);
                  mon_w = mon_w << 8;
               end
               if (InLast || pend.size() == 16) close_block(InLast);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] lb);
      int n;
      n = 0;
      InData = d; InLast = l; InLastBytes = lb; InValid = 1'b1;
      @(negedge Clk);
      while (!InReady && n < 200) begin
         @(negedge Clk);
         n++;
      end
      check("send_hs", InReady, 1'b1);
      @(posedge Clk);
      #1;
      InValid = 1'b0; InLast = 1'b0; InLastBytes = 2'd0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      BlkReady = 1'b1;
      while ((BlkValid || sb.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      check("drain_valid", BlkValid, 1'b0);
      check("drain_sb_empty", sb.size(), 0);
   endtask

   function automatic logic [31:0] mkword(input logic [7:0] base, input int k);
      logic [7:0] b0;
      b0 = base + 8'(4 * k);
      return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
   endfunction

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int need;
      Rst = 1'b1; Enable = 1'b1; InValid = 1'b0; InLast = 1'b0; InLastBytes = 2'd0;
      InData = '0; BlkReady = 1'b1;
      tests = 0; fails = 0; mon_en = 1'b0; hold_v = 1'b0; cnt_m = '0;
      tick();
      tick();
      Rst = 1'b0;
      mon_en = 1'b1;
      check("rst_in_ready", InReady, 1'b0);
      check("rst_valid", BlkValid, 1'b0);
      check("rst_data", BlkData, 128'h0);
      check("rst_bytes", BlkBytes, 5'd0);
      check("rst_last", BlkLast, 1'b0);
      check("rst_count", BlkCount, 16'h0);
      tick();
      check("rdy_after_rst", InReady, 1'b1);

      // Two full blocks, last on word 8.
      for (int k = 0; k < 8; k++) begin
         send_word(mkword(8'h00, k), k == 7, 2'd0);
         if (k == 2) check("t1_no_early_valid", BlkValid, 1'b0);
         if (k == 3) begin
            check("t1_lat_b1", BlkValid, 1'b1);
            check("t1_data_b1", BlkData, 128'h000102030405060708090A0B0C0D0E0F);
         end
      end
      check("t1_lat_b2", BlkValid, 1'b1);
      check("t1_data_b2", BlkData, 128'h101112131415161718191A1B1C1D1E1F);
      check("t1_bytes_b2", BlkBytes, 5'd16);
      check("t1_cnt_mid", BlkCount, 16'd1);
`ifdef IBR128_PKCS7_PAD_EN
      check("t1_last_b2", BlkLast, 1'b0);
      check("t1_padblk_rdy", InReady, 1'b0);
      tick();
      check("t1_cnt2", BlkCount, 16'd2);
      check("t1_pad_valid", BlkValid, 1'b1);
      check("t1_pad_data", BlkData, {16{8'h10}});
      check("t1_pad_bytes", BlkBytes, 5'd0);
      check("t1_pad_last", BlkLast, 1'b1);
      tick();
      check("t1_cnt3", BlkCount, 16'd3);
`else
      check("t1_last_b2", BlkLast, 1'b1);
      tick();
      check("t1_cnt2", BlkCount, 16'd2);
      check("t1_idle", BlkValid, 1'b0);
`endif
      drain();

      // Short final block of 5 bytes.
      send_word(32'hAABBCCDD, 1'b0, 2'd0);
      send_word(32'h11223344, 1'b1, 2'd1);
      check("t2_bytes", BlkBytes, 5'd5);
      check("t2_last", BlkLast, 1'b1);
`ifdef IBR128_PKCS7_PAD_EN
      check("t2_data", BlkData, 128'hAABBCCDD110B0B0B0B0B0B0B0B0B0B0B);
`else
      check("t2_data", BlkData, 128'hAABBCCDD110000000000000000000000);
`endif
      drain();

      // Output back-pressure: block 1 held, block 2 stalls in assembly.
      BlkReady = 1'b0;
      for (int k = 0; k < 8; k++) send_word(mkword(8'h20, k), k == 7, 2'd0);
      check("t3_stall_rdy", InReady, 1'b0);
      check("t3_hold_valid", BlkValid, 1'b1);
      check("t3_hold_b1", BlkData, 128'h202122232425262728292A2B2C2D2E2F);
      tick();
      tick();
      check("t3_still_b1", BlkData, 128'h202122232425262728292A2B2C2D2E2F);
      check("t3_still_stall", InReady, 1'b0);
      BlkReady = 1'b1;
      tick();
      check("t3_b2_valid", BlkValid, 1'b1);
      check("t3_b2_data", BlkData, 128'h303132333435363738393A3B3C3D3E3F);
      drain();

      // Reset in the middle of a block.
      send_word(mkword(8'h50, 0), 1'b0, 2'd0);
      send_word(mkword(8'h50, 1), 1'b0, 2'd0);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      check("t4_valid", BlkValid, 1'b0);
      check("t4_data", BlkData, 128'h0);
      check("t4_count", BlkCount, 16'h0);
      check("t4_rdy", InReady, 1'b0);
      for (int k = 0; k < 4; k++) send_word(mkword(8'h60, k), 1'b0, 2'd0);
      check("t4_clean_data", BlkData, 128'h606162636465666768696A6B6C6D6E6F);
      check("t4_clean_bytes", BlkBytes, 5'd16);
      check("t4_clean_last", BlkLast, 1'b0);
      drain();

      // Flush via Enable with a block waiting and a word in assembly.
      for (int k = 0; k < 4; k++) send_word(32'hC0000000 | 32'(k), 1'b1, 2'd0);
      drain();
      check("t5_count5", BlkCount, 16'd5);
      BlkReady = 1'b0;
      send_word(32'hCAFEF00D, 1'b1, 2'd0);
      send_word(32'h12345678, 1'b0, 2'd0);
      check("t5_pre_valid", BlkValid, 1'b1);
      Enable = 1'b0;
      tick();
      check("t5_valid", BlkValid, 1'b0);
      check("t5_count_hold", BlkCount, 16'd5);
      check("t5_rdy_low", InReady, 1'b0);
      check("t5_data", BlkData, 128'h0);
      Enable = 1'b1;
      BlkReady = 1'b1;
      tick();
      check("t5_rdy_back", InReady, 1'b1);
      for (int k = 0; k < 4; k++) send_word(mkword(8'h70, k), 1'b0, 2'd0);
      check("t5_clean_data", BlkData, 128'h707172737475767778797A7B7C7D7E7F);
      drain();

      // Counter wrap using one-word messages at one block per cycle.
      need = 65535 - int'(cnt_m);
      for (int i = 0; i < need; i++) send_word(32'(i), 1'b1, 2'(i));
      drain();
      check("t6_cnt_ffff", BlkCount, 16'hFFFF);
      send_word(32'hDEADBEEF, 1'b1, 2'd0);
      drain();
      check("t6_cnt_wrap", BlkCount, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ibr128_block_packer.md
Name: ibr128_block_packer

Overview:
- Upstream feeder for the 128-bit opmode/cipher path: packs a 32-bit word stream (valid/ready) into 128-bit plaintext blocks.
- Presents each block on a valid/ready interface to the opmode stage.
- Pads the final partial block, tags it with a last flag and valid-byte count, and double-buffers so word intake continues while a finished block waits.

Parameters:
- WORD_W, 32, input word width; fixed by design, must divide BLK_W.
- BLK_W, 128, block width.
- CNT_W, 16, width of the emitted-block counter.

Ports:
- Clk  in  1  single clock, all logic rising-edge.
- Rst  in  1  synchronous active-high reset.
- Enable  in  1  low = synchronous flush (see Behaviour).
- InData  in  32  input word; [31:24] is first byte in stream order.
- InValid  in  1  InData valid.
- InLast  in  1  word is final word of message.
- InLastBytes  in  2  valid bytes in final word, 0 encodes 4; high bytes valid; ignored unless InLast.
- InReady  out  1  word accepted when InValid & InReady.
- BlkData  out  128  assembled block; first word at [127:96].
- BlkBytes  out  5  message bytes in block, 1..16 (pad block reports 0).
- BlkLast  out  1  block is final block of message.
- BlkValid  out  1  block available.
- BlkReady  in  1  block consumed when BlkValid & BlkReady.
- BlkCount  out  CNT_W  blocks consumed since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (Rst=1 at edge): InReady=0 that cycle, then 1 next cycle if Enable. BlkValid=0, BlkData=0, BlkBytes=0, BlkLast=0, BlkCount=0. Assembly index=0, state=FILL. Reset mid-block discards partial data.
- Enable=0: same clear as reset except BlkCount holds. InReady=0 while low.
- Storage: assembly register ASM plus word index IDX (0..3). Output register OUT with full flag = BlkValid.
- States:
  - FILL: InReady=1; each accepted word is written to ASM slot IDX (slot 0 = [127:96]), IDX++.
  - STALL: block complete but OUT occupied; InReady=0.
  - PADBLK: (PAD_EN only) pad block pending; InReady=0.
- Block completion: an accepted word at IDX=3, or any accepted word with InLast.
  - If OUT empty or drained the same cycle (BlkValid & BlkReady), the completed block loads OUT at that edge and IDX resets to 0.
  - Otherwise go to STALL; transfer to OUT on the first cycle OUT drains; return to FILL.
- Latency: BlkValid rises the cycle after the completing word's handshake.
- Throughput: 1 word/cycle sustained while BlkReady=1; no bubble between blocks.
- Partial final block: byte count = 4*IDX + (InLastBytes==0 ? 4 : InLastBytes). Unused low bytes are filled per the padding rule; BlkLast=1.
- OUT holds BlkData/BlkBytes/BlkLast stable while BlkValid & !BlkReady.
- BlkCount increments on each BlkValid & BlkReady, wrapping 0xFFFF -> 0.
- InLast with InValid=0 is ignored. InLastBytes is only sampled with InLast.

Optional Feature:
- Macro: IBR128_PKCS7_PAD_EN.
- Defined: unused bytes = 16 - BlkBytes (PKCS#7). If the final block is exactly 16 bytes, it goes out with BlkLast=0, then PADBLK emits an extra block of all 0x10 with BlkBytes=0, BlkLast=1. InReady=0 until the pad block loads OUT.
- Undefined: unused bytes = 0x00; no extra pad block; PADBLK state absent.

Decomposition:
- Package ibr128_pkg: BLK_W, WORD_W, WORDS_PER_BLK=4, the state enum {FILL, STALL, PADBLK}, and a pad-fill function (bytes -> 128-bit mask/fill).
- Sub-module ibr128_pad_fill: combinational; takes a partial block and byte count, outputs the padded block. Keeps padding isolated for unit test.

Test Plan:
- 8 words 0x00010203..0x1C1D1E1F, BlkReady=1, last on word 8 -> two blocks, 0x000102..0F then 0x10..1F. BlkValid 1 cycle after words 4 and 8; second has BlkLast=1, BlkBytes=16. BlkCount=2. With PAD_EN, a third block of all 0x10 follows, BlkBytes=0.
- 2 words, last with InLastBytes=1, data 0xAABBCCDD, 0x11223344 -> BlkBytes=5. Data 0xAABBCCDD11000000_0000000000000000; PAD_EN: 0xAABBCCDD110B0B0B_0B0B0B0B0B0B0B0B.
- BlkReady=0 for 10 cycles while 8 words stream -> block 1 held stable, block 2 assembled. InReady=0 (STALL) after word 8. On BlkReady=1, both blocks drain on consecutive cycles, no loss or reorder.
- Rst asserted after 2 words of a block -> all outputs 0 next cycle. Subsequent 4 words form a clean block with no stale data.
- Enable dropped with BlkValid=1 and BlkCount=5 -> BlkValid=0, IDX=0, BlkCount stays 5.
- Preload BlkCount=0xFFFF via 65535 handshakes (or a forced value), then one more -> BlkCount=0x0000.
